mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory bus (addr_out/data_out/data_in, rom_rd/ram_rd/ram_wr) between two
//  requesters: instruction fetch (port F, ROM reads only) and data access (port D, RAM read/write).
//  Sits between control and the ROM/RAM models and serialises one transaction at a time, so ROM
//  and RAM never drive the shared data_in bus in the same cycle. Round-robin on contention.
// PARAMETERS
//  DATA_W  14  data bus width
//  ADDR_W  12  address bus width
//  RD_LAT  1   memory read latency in cycles (rden cycle to data_in valid), legal 1..7
// PORTS
//  clk       in   1       clock, all logic on posedge
//  reset     in   1       synchronous, active-low reset
//  f_req     in   1       fetch request; held high with f_addr stable until f_gnt
//  f_addr    in   ADDR_W  fetch (ROM) address
//  f_gnt     out  1       one-cycle pulse: fetch issued to ROM
//  f_rdata   out  DATA_W  fetch read data, valid while f_valid
//  f_valid   out  1       one-cycle pulse: f_rdata valid
//  d_req     in   1       data request; held high with d_we/d_addr/d_wdata stable until d_gnt
//  d_we      in   1       1 = RAM write, 0 = RAM read
//  d_addr    in   ADDR_W  data (RAM) address
//  d_wdata   in   DATA_W  write data
//  d_gnt     out  1       one-cycle pulse: data access issued (write complete on this pulse)
//  d_rdata   out  DATA_W  data read result, valid while d_valid
//  d_valid   out  1       one-cycle pulse: d_rdata valid (reads only)
//  addr_out  out  ADDR_W  memory address
//  data_out  out  DATA_W  RAM write data
//  rom_rd / ram_rd / ram_wr  out 1  memory strobes
//  data_in   in   DATA_W  shared ROM/RAM read data
// BEHAVIOUR
//  - reset==0 at a clock edge: state IDLE, every output 0, wait counter 0, last_grant=D (F wins
//    the first tie); any in-flight transaction is abandoned, no gnt/valid issued for it.
//  - States: IDLE -> ISSUE -> WAIT -> IDLE (reads); IDLE -> ISSUE -> IDLE (writes).
//  - IDLE: if any req high, pick winner, latch its addr/we/wdata and port id, go ISSUE.
//    Only F -> F; only D -> D; both -> port opposite to last_grant; last_grant updated on pick.
//  - ISSUE (exactly 1 cycle): addr_out=latched addr; F: rom_rd=1; D read: ram_rd=1;
//    D write: ram_wr=1, data_out=wdata. Winner's gnt=1. Write -> IDLE; read -> WAIT, counter=RD_LAT.
//  - WAIT: addr_out held, strobes 0; counter decrements; when counter reaches 1, capture data_in
//    into winner's rdata register and pulse valid the following cycle while returning to IDLE.
//    Read latency req-seen-in-IDLE to valid = 2+RD_LAT cycles; write = 2 cycles.
//  - Only one strobe ever high per cycle; rom_rd and ram_rd never both high (checked by bench).
//  - Outside ISSUE/WAIT addr_out=0, data_out=0. rdata registers hold until the next capture.
//  - Request latched in IDLE always completes even if req drops afterwards (protocol violation,
//    tolerated). A req arriving during ISSUE/WAIT is considered in the next IDLE cycle.
//  - Back-to-back: one IDLE cycle between transactions; with both reqs held, grants alternate
//    F,D,F,D; neither port waits more than one foreign transaction.
//  - ADDR_W/DATA_W pass through unmodified; no address decode, port alone selects ROM vs RAM.
// STRUCTURE
//  - Shared header mem_arb_defs.vh: state encodings (ST_IDLE, ST_ISSUE, ST_WAIT), port ids
//    (PORT_F=0, PORT_D=1), RD_LAT counter width (3).
//  - Sub-module rr_arbiter2: 2-request round-robin picker (req[1:0], last_grant in, onehot
//    grant out, combinational); FSM, latches and counter stay in mem_bus_arbiter.
// TESTING
//  - Reset: hold reset=0 3 cycles with f_req=d_req=1 -> all outputs 0, no strobes; release ->
//    f_gnt first (tie favours F).
//  - Single fetch: f_req, f_addr=12'h010, ROM[0x010]=14'h1ABC, RD_LAT=1 -> rom_rd+f_gnt 1 cycle
//    after req seen, f_valid with f_rdata=14'h1ABC 2 cycles after that.
//  - Write then read: D write addr 12'h020 data 14'h0155 -> ram_wr=1, data_out=14'h0155, d_gnt;
//    then D read 12'h020 -> d_valid with d_rdata=14'h0155, f_valid stays 0.
//  - Contention: f_req and d_req held 8 transactions -> grants alternate F,D,F,D...; strobes
//    mutually exclusive every cycle; no gnt without prior IDLE cycle.
//  - Reset mid-read: reset=0 during WAIT (RD_LAT=3) -> no valid pulse, state IDLE, outputs 0.
//  - Early drop: f_req high one cycle only -> transaction still completes with f_gnt and f_valid.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared definitions for the memory bus arbiter: FSM state encodings,
//   requester port identifiers and the width of the read-latency counter.
//   Imported by rr_arbiter2 and mem_bus_arbiter.
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    // Arbiter FSM states. IDLE picks a winner, ISSUE drives the strobe for
    // exactly one cycle, WAIT counts down the memory read latency.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Requester identifiers. The value doubles as the bit index of that
    // requester in the two-bit request/grant vectors.
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Read-latency counter width; holds RD_LAT values 1..7.
    localparam int CNT_W = 3;

    // Port id of a one-hot grant vector (bit 1 set means the data port).
    function automatic logic grant_port(input logic [1:0] grant);
        return grant[PORT_D];
    endfunction

endpackage : mem_bus_arbiter_pkg

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Purely combinational two-requester round-robin picker.
//   A lone request wins outright; on a tie the requester that was NOT granted
//   last wins, so neither side waits behind more than one foreign grant.
// Ports
//   req        in  [1:0]  request vector, bit PORT_F = fetch, bit PORT_D = data
//   last_grant in  1      port id of the most recent grant
//   grant      out [1:0]  one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            if (last_grant == PORT_D) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end
    end

endmodule : rr_arbiter2

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Serialises instruction fetches (port F, ROM reads) and data accesses
//   (port D, RAM reads/writes) onto one shared memory bus so that ROM and RAM
//   never drive data_in in the same cycle. One transaction is in flight at a
//   time; ties are broken round-robin.
//
//   Transaction flow:
//     reads : IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> IDLE (valid pulse)
//     writes: IDLE -> ISSUE -> IDLE (d_gnt marks completion)
//
// Handshake
//   A requester raises *_req with its address/data stable and keeps it until
//   its *_gnt pulse. The request is latched in IDLE, so the transaction
//   completes even if req drops afterwards. Read data is presented on
//   *_rdata together with a one-cycle *_valid pulse; *_rdata then holds until
//   the next read for that port completes.
//
// Ports
//   clk, reset                 clock (posedge), synchronous active-low reset
//   f_req/f_addr               fetch request and ROM address
//   f_gnt/f_rdata/f_valid      fetch issue pulse, read data, data-valid pulse
//   d_req/d_we/d_addr/d_wdata  data request, write enable, RAM address, data
//   d_gnt/d_rdata/d_valid      data issue pulse, read data, data-valid pulse
//   addr_out/data_out          shared memory address and RAM write data
//   rom_rd/ram_rd/ram_wr       memory strobes (at most one high per cycle)
//   data_in                    shared ROM/RAM read data
//
// Parameters
//   DATA_W  data bus width
//   ADDR_W  address bus width
//   RD_LAT  cycles from read strobe to data_in valid, 1..7
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_valid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,

    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              rom_rd,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] data_in
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT);

    // FSM state
    state_t              r_state;
    state_t              w_next_state;

    // Transaction latched in IDLE
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    // Read-latency countdown and round-robin history
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last_grant;

    // Per-port read results
    logic [DATA_W-1:0]   r_f_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_f_valid;
    logic                r_d_valid;

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_pick;
    logic                w_win_port;
    logic                w_read_done;

    assign w_req[PORT_F] = f_req;
    assign w_req[PORT_D] = d_req;

    rr_arbiter2 u_rr (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    assign w_pick      = (w_grant != 2'b00);
    assign w_win_port  = grant_port(w_grant);
    // The counter was loaded with RD_LAT on entry to WAIT, so data_in is
    // valid in the WAIT cycle where the counter shows 1.
    assign w_read_done = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_port       <= PORT_F;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_last_grant <= PORT_D;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
            r_f_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_f_valid <= 1'b0;
            r_d_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pick) begin
                        r_port       <= w_win_port;
                        r_last_grant <= w_win_port;
                        if (w_win_port == PORT_D) begin
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= f_addr;
                            r_wdata <= '0;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_cnt <= LAT_INIT;
                end

                ST_WAIT: begin
                    if (w_read_done) begin
                        r_cnt <= '0;
                        if (r_port == PORT_F) begin
                            r_f_rdata <= data_in;
                            r_f_valid <= 1'b1;
                        end else begin
                            r_d_rdata <= data_in;
                            r_d_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and bus outputs (decoded from registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        addr_out     = '0;
        data_out     = '0;
        rom_rd       = 1'b0;
        ram_rd       = 1'b0;
        ram_wr       = 1'b0;
        f_gnt        = 1'b0;
        d_gnt        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick) begin
                    w_next_state = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                addr_out = r_addr;
                if (r_port == PORT_F) begin
                    rom_rd       = 1'b1;
                    f_gnt        = 1'b1;
                    w_next_state = ST_WAIT;
                end else if (r_we) begin
                    ram_wr       = 1'b1;
                    data_out     = r_wdata;
                    d_gnt        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    ram_rd       = 1'b1;
                    d_gnt        = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Address stays on the bus while the memory returns data.
                addr_out = r_addr;
                if (w_read_done) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign f_rdata = r_f_rdata;
    assign f_valid = r_f_valid;
    assign d_rdata = r_d_rdata;
    assign d_valid = r_d_valid;

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Main instance (RD_LAT=1) with ROM/RAM model and scoreboard, plus a second
//   instance (RD_LAT=3) used for long-latency and reset-during-read checks.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int DW = 14;
    localparam int AW = 12;
    localparam logic [DW-1:0] POISON = 14'h2D2D;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic          reset;
    logic          f_req, f_gnt, f_valid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_we, d_gnt, d_valid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out, data_in;
    logic          rom_rd, ram_rd, ram_wr;

    // ---------------- second DUT signals ----------------
    logic          rst3;
    logic          f_req3, f_gnt3, f_valid3;
    logic [AW-1:0] f_addr3;
    logic [DW-1:0] f_rdata3;
    logic          d_req3, d_we3, d_gnt3, d_valid3;
    logic [AW-1:0] d_addr3;
    logic [DW-1:0] d_wdata3, d_rdata3;
    logic [AW-1:0] addr_out3;
    logic [DW-1:0] data_out3, data_in3;
    logic          rom_rd3, ram_rd3, ram_wr3;

    mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_valid(f_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
        .addr_out(addr_out), .data_out(data_out),
        .rom_rd(rom_rd), .ram_rd(ram_rd), .ram_wr(ram_wr), .data_in(data_in)
    );

    mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(rst3),
        .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rdata(f_rdata3), .f_valid(f_valid3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_gnt(d_gnt3), .d_rdata(d_rdata3), .d_valid(d_valid3),
        .addr_out(addr_out3), .data_out(data_out3),
        .rom_rd(rom_rd3), .ram_rd(ram_rd3), .ram_wr(ram_wr3), .data_in(data_in3)
    );

    // ---------------- memory models ----------------
    logic [DW-1:0] rom [0:4095];
    logic [DW-1:0] ram [0:4095];

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = {2'b00, a} * 14'd29 + 14'h0301;
        return t;
    endfunction

    // Latency-1 model for the main instance; data_in is poisoned when idle.
    logic          m1_v;
    logic [DW-1:0] m1_d;
    always @(posedge clk) begin
        if (ram_wr) ram[addr_out] <= data_out;
        m1_v <= rom_rd | ram_rd;
        m1_d <= rom_rd ? rom[addr_out] : ram[addr_out];
    end
    assign data_in = m1_v ? m1_d : POISON;

    // Latency-3 model for the second instance.
    logic [2:0]    m3_v;
    logic [DW-1:0] m3_d0, m3_d1, m3_d2;
    always @(posedge clk) begin
        m3_v  <= {m3_v[1:0], rom_rd3 | ram_rd3};
        m3_d0 <= rom_rd3 ? rom[addr_out3] : ram[addr_out3];
        m3_d1 <= m3_d0;
        m3_d2 <= m3_d1;
    end
    assign data_in3 = m3_v[2] ? m3_d2 : POISON;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] f_exp_q[$];
    logic [DW-1:0] d_exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle bus monitor and read-data scoreboard for the main instance.
    state_t prev_state = ST_IDLE;
    always @(negedge clk) begin
        if (reset) begin
            if (rom_rd | ram_rd | ram_wr)
                chk("strobe_onehot", 64'($countones({rom_rd, ram_rd, ram_wr})), 64'd1);
            if (f_gnt | d_gnt) begin
                chk("gnt_after_idle", 64'(prev_state), 64'(ST_IDLE));
                chk("gnt_single", 64'(f_gnt & d_gnt), 64'd0);
            end
            if (f_valid) begin
                if (f_exp_q.size() == 0) chk("f_valid_unexpected", 64'(f_valid), 64'd0);
                else chk("f_rdata", 64'(f_rdata), 64'(f_exp_q.pop_front()));
            end
            if (d_valid) begin
                if (d_exp_q.size() == 0) chk("d_valid_unexpected", 64'(d_valid), 64'd0);
                else chk("d_rdata", 64'(d_rdata), 64'(d_exp_q.pop_front()));
            end
        end
        prev_state = dut.r_state;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    // Drive one isolated transaction from an IDLE cycle and check its timing.
    task automatic apply_vec(input vec_t v);
        int  cnt;
        logic seen;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            if (!v.we) d_exp_q.push_back(v.exp_rdata);
        end else begin
            f_req = 1'b1; f_addr = v.addr;
            f_exp_q.push_back(v.exp_rdata);
        end
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 8) begin
            @(negedge clk); cnt++;
            seen = f_gnt | d_gnt;
        end
        chk("gnt_latency", 64'(cnt), 64'd1);
        chk("gnt_port", 64'({f_gnt, d_gnt}), v.is_d ? 64'b01 : 64'b10);
        chk("strobes", 64'({rom_rd, ram_rd, ram_wr}),
            !v.is_d ? 64'b100 : (v.we ? 64'b001 : 64'b010));
        chk("addr_out", 64'(addr_out), 64'(v.addr));
        chk("data_out", 64'(data_out), (v.is_d && v.we) ? 64'(v.wdata) : 64'd0);
        f_req = 1'b0; d_req = 1'b0;
        if (v.is_d && v.we) begin
            @(negedge clk);
            chk("write_no_valid", 64'({f_valid, d_valid}), 64'd0);
            chk("write_idle_addr", 64'(addr_out), 64'd0);
        end else begin
            seen = 1'b0;
            while (!seen && cnt < 16) begin
                @(negedge clk); cnt++;
                seen = v.is_d ? d_valid : f_valid;
                if (!seen) begin
                    chk("wait_addr", 64'(addr_out), 64'(v.addr));
                    chk("wait_strobes", 64'({rom_rd, ram_rd, ram_wr}), 64'd0);
                end
            end
            chk("read_latency", 64'(cnt), 64'd3);
            chk("valid_idle_addr", 64'(addr_out), 64'd0);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((f_exp_q.size() + d_exp_q.size()) != 0 && k < 40) begin
            @(negedge clk); k++;
        end
        chk(name, 64'(f_exp_q.size() + d_exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   cnt, ng;
        logic seen;

        for (int i = 0; i < 4096; i++) begin
            rom[i] = rom_val(AW'(i));
            ram[i] = '0;
        end
        rom[16] = 14'h1ABC;

        vecs[0]  = '{1'b0, 1'b0, 12'h010, 14'h0000, 14'h1ABC};
        vecs[1]  = '{1'b1, 1'b1, 12'h020, 14'h0155, 14'h0000};
        vecs[2]  = '{1'b1, 1'b0, 12'h020, 14'h0000, 14'h0155};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 14'h0000, rom_val(12'h000)};
        vecs[4]  = '{1'b0, 1'b0, 12'hFFF, 14'h0000, rom_val(12'hFFF)};
        vecs[5]  = '{1'b1, 1'b1, 12'hFFF, 14'h3FFF, 14'h0000};
        vecs[6]  = '{1'b1, 1'b0, 12'hFFF, 14'h0000, 14'h3FFF};
        vecs[7]  = '{1'b1, 1'b1, 12'h000, 14'h0000, 14'h0000};
        vecs[8]  = '{1'b1, 1'b0, 12'h000, 14'h0000, 14'h0000};
        vecs[9]  = '{1'b1, 1'b1, 12'h123, 14'h2AAA, 14'h0000};
        vecs[10] = '{1'b1, 1'b0, 12'h123, 14'h0000, 14'h2AAA};
        vecs[11] = '{1'b0, 1'b0, 12'h123, 14'h0000, rom_val(12'h123)};

        // Reset held with both requests high: nothing may happen.
        reset = 1'b0;
        f_req = 1'b1; f_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020; d_wdata = '0;
        rst3 = 1'b0; f_req3 = 1'b0; f_addr3 = '0;
        d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0; d_wdata3 = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctrl", 64'({f_gnt, f_valid, d_gnt, d_valid, rom_rd, ram_rd, ram_wr}), 64'd0);
            chk("rst_rdata", 64'({f_rdata, d_rdata}), 64'd0);
            chk("rst_bus", 64'({addr_out, data_out}), 64'd0);
        end
        chk("rst_state", 64'(dut.r_state), 64'(ST_IDLE));

        // Release: F wins the first tie, D follows after one IDLE cycle.
        reset = 1'b1;
        f_exp_q.push_back(14'h1ABC);
        d_exp_q.push_back(14'h0000);
        @(negedge clk);
        chk("first_tie_f", 64'({f_gnt, d_gnt}), 64'b10);
        f_req = 1'b0;
        cnt = 1; seen = 1'b0;
        while (!seen && cnt < 12) begin
            @(negedge clk); cnt++;
            seen = d_gnt;
        end
        chk("second_d_gnt_at", 64'(cnt), 64'd4);
        d_req = 1'b0;
        drain("post_reset_drain");

        // Table-driven single transactions.
        for (int i = 0; i < NV; i++) apply_vec(vecs[i]);
        drain("table_drain");

        // Contention: reset restores last_grant=D, then both held for 8 grants.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_state", 64'(dut.r_state), 64'(ST_IDLE));
        f_req = 1'b1; f_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h123;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_exp_q.push_back(14'h1ABC);
            d_exp_q.push_back(14'h2AAA);
        end
        ng = 0; cnt = 0;
        while (ng < 8 && cnt < 100) begin
            @(negedge clk); cnt++;
            if (f_gnt | d_gnt) begin
                chk("rr_order", 64'({f_gnt, d_gnt}), ng[0] ? 64'b01 : 64'b10);
                ng++;
                if (ng == 8) begin
                    f_req = 1'b0; d_req = 1'b0;
                end
            end
        end
        chk("rr_grant_count", 64'(ng), 64'd8);
        f_req = 1'b0; d_req = 1'b0;
        drain("contention_drain");

        // Early drop: request visible for a single IDLE cycle only.
        f_req = 1'b1; f_addr = 12'h055;
        f_exp_q.push_back(rom_val(12'h055));
        @(negedge clk);
        f_req = 1'b0;
        chk("early_drop_gnt", 64'(f_gnt), 64'd1);
        drain("early_drop_valid");

        // Long latency on the RD_LAT=3 instance: valid 5 cycles after req.
        rst3 = 1'b1;
        @(negedge clk);
        f_req3 = 1'b1; f_addr3 = 12'h010;
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 8) begin
            @(negedge clk); cnt++;
            seen = f_gnt3;
        end
        chk("lat3_gnt", 64'(cnt), 64'd1);
        chk("lat3_rom_rd", 64'({rom_rd3, ram_rd3, ram_wr3}), 64'b100);
        f_req3 = 1'b0;
        seen = 1'b0;
        while (!seen && cnt < 16) begin
            @(negedge clk); cnt++;
            seen = f_valid3;
        end
        chk("lat3_valid_at", 64'(cnt), 64'd5);
        chk("lat3_rdata", 64'(f_rdata3), 64'h1ABC);

        // Reset during WAIT: read abandoned, no valid, everything cleared.
        f_req3 = 1'b1; f_addr3 = 12'h0FF;
        @(negedge clk);
        chk("midrst_gnt", 64'(f_gnt3), 64'd1);
        f_req3 = 1'b0;
        @(negedge clk);
        chk("midrst_in_wait", 64'(dut3.r_state), 64'(ST_WAIT));
        rst3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        chk("midrst_state", 64'(dut3.r_state), 64'(ST_IDLE));
        chk("midrst_ctrl", 64'({f_gnt3, f_valid3, d_gnt3, d_valid3, rom_rd3, ram_rd3, ram_wr3}), 64'd0);
        chk("midrst_rdata", 64'({f_rdata3, d_rdata3}), 64'd0);
        chk("midrst_bus", 64'({addr_out3, data_out3}), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 64'({f_valid3, f_gnt3, rom_rd3}), 64'd0);
        end

        chk("final_queues_empty", 64'(f_exp_q.size() + d_exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog: guarantees termination even if a loop bound is never reached.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_bus_arbiter
